// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared ALU control codes and arbiter FSM state encoding.
// Imported by every file of the ALU arbiter slice.
package alu_arbiter_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational 2-way round-robin grant.
// Ports: valid[1:0], lastGrant in; anyValid, grant (winning port) out.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       lastGrant,
  output logic       anyValid,
  output logic       grant
);

  always_comb begin
    anyValid = |valid;
    grant    = 1'b0;
    unique case (valid)
      2'b11:   grant = ~lastGrant;
      2'b10:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two valid/ready requesters.
// Ports: clk, reset; req0/1 (valid, ready, a, b, ctl); rsp0/1 (valid,
// ready, result, zero); alu_a/b/ctl out, alu_result/zero in; busy, grant_id.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTL_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTL_W-1:0]  req0_ctl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTL_W-1:0]  req1_ctl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTL_W-1:0]  alu_ctl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy,
  output logic              grant_id
);

  state_t state;
  state_t stateNext;

  logic              lastGrant;
  logic              grantId;
  logic              winner;
  logic              anyValid;
  logic              accept;
  logic              rspFire;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic [CTL_W-1:0]  opCtl;
  logic [DATA_W-1:0] rspResult;
  logic              rspZero;

  rr_arbiter2 uArb (
    .valid     ({req1_valid, req0_valid}),
    .lastGrant (lastGrant),
    .anyValid  (anyValid),
    .grant     (winner)
  );

  assign accept  = (state == IDLE) && anyValid && !reset;
  assign rspFire = (state == RESP) &&
                   (grantId ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (accept) stateNext = EXEC;
      EXEC:    stateNext = RESP;
      RESP:    if (rspFire) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrant <= 1'b1;
      grantId   <= 1'b0;
      opA       <= '0;
      opB       <= '0;
      opCtl     <= '0;
      rspResult <= '0;
      rspZero   <= 1'b0;
    end else begin
      if (accept) begin
        grantId <= winner;
        opA     <= winner ? req1_a   : req0_a;
        opB     <= winner ? req1_b   : req0_b;
        opCtl   <= winner ? req1_ctl : req0_ctl;
      end
      if (state == EXEC) begin
        rspResult <= alu_result;
        rspZero   <= alu_zero;
      end
      if (rspFire) lastGrant <= grantId;
    end
  end

  // ALU inputs are parked at zero/ADD outside EXEC to avoid toggling.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_ctl     = CTL_W'(ALU_ADD);
    unique case (state)
      IDLE: begin
        req0_ready = accept && !winner;
        req1_ready = accept &&  winner;
      end
      EXEC: begin
        alu_a   = opA;
        alu_b   = opB;
        alu_ctl = opCtl;
      end
      RESP: begin
        rsp0_valid = !grantId;
        rsp1_valid =  grantId;
      end
      default: ;
    endcase
    rsp0_result = rsp0_valid ? rspResult : '0;
    rsp0_zero   = rsp0_valid && rspZero;
    rsp1_result = rsp1_valid ? rspResult : '0;
    rsp1_zero   = rsp1_valid && rspZero;
  end

  assign busy     = (state != IDLE);
  assign grant_id = grantId;

endmodule
